mem_boot_arbiter: RTL and testbench

MEM_BOOT_ARBITER -- requirements
Module: mem_boot_arbiter

---
 rtl/mem_boot_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_boot_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_arbiter.sv
// mem_boot_arbiter: boot-time loader / CPU / debug arbiter for a single-port
// 16x8 memory with combinational read and clocked write.
// LOAD state: the host streams a program image into memory while the CPU is
// held in reset. RUN state: the CPU owns the memory. Debug reads are slotted
// into idle CPU cycles.
// Build option: define MEM_BOOT_ARBITER_DEBUG_EN to add the dbg_* read port.
// Without it, the memory mux selects only between the loader and the CPU.
module mem_boot_arbiter (
  input  logic       clk,
  input  logic       clr,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  input  logic       host_last,
  output logic       host_ready,
  input  logic       host_reload,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [3:0] cpu_address,
  input  logic [7:0] cpu_memoryIn,
  output logic [7:0] cpu_memoryOut,
  output logic       cpu_clr,
  // NOTE: the memory array lives outside this block, so clr never clears the
  // program image; only control state is reset here.
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_address,
  output logic [7:0] mem_din,
  input  logic [7:0] mem_dout,
  output logic       boot_done
`ifdef MEM_BOOT_ARBITER_DEBUG_EN
  ,
  input  logic       dbg_req,
  input  logic [3:0] dbg_addr,
  output logic       dbg_ack,
  output logic [7:0] dbg_data
`endif
);

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state;
  logic [3:0] loadPtr;
  logic       loadEnd;
  logic       dbgGrant;
  logic [3:0] dbgAddr;

  // The image ends on an explicit last byte or when the final address is filled.
  assign loadEnd = host_last || (loadPtr == 4'hF);

  // Load/run sequencing; the pointer restarts at 0 whenever a load begins or ends.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= LOAD;
      loadPtr <= '0;
    end else if (state == LOAD) begin
      if (host_valid) begin
        if (loadEnd) begin
          state   <= RUN;
          loadPtr <= '0;
        end else begin
          loadPtr <= loadPtr + 4'd1;
        end
      end
    end else if (host_reload) begin
      state   <= LOAD;
      loadPtr <= '0;
    end
  end

`ifdef MEM_BOOT_ARBITER_DEBUG_EN
  // A debug read only borrows a RUN cycle the CPU leaves idle; the ack cycle
  // itself is never granted, so a held request cannot retrigger early.
  assign dbgGrant = (state == RUN) && !clr && dbg_req && !dbg_ack &&
                    !cpu_read && !cpu_write && !host_reload;
  assign dbgAddr  = dbg_addr;

  // Capture the granted byte and acknowledge it one cycle later.
  always_ff @(posedge clk) begin
    if (clr) begin
      dbg_ack  <= 1'b0;
      dbg_data <= 8'h00;
    end else begin
      dbg_ack <= dbgGrant;
      if (dbgGrant) begin
        dbg_data <= mem_dout;
      end
    end
  end
`else
  assign dbgGrant = 1'b0;
  assign dbgAddr  = 4'h0;
`endif

  // Memory ownership mux and status outputs; clr forces the LOAD-state view.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    host_ready  = clr || (state == LOAD);
    cpu_clr     = clr || (state == LOAD);
    boot_done   = !clr && (state == RUN);
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = loadPtr;
    mem_din     = host_data;
    if (clr) begin
      // Hold the memory quiet while reset is applied.
    end else if (state == LOAD) begin
      mem_write = host_valid;
    end else if (dbgGrant) begin
      mem_read    = 1'b1;
      mem_address = dbgAddr;
      mem_din     = cpu_memoryIn;
    end else begin
      mem_read    = cpu_read;
      mem_write   = cpu_write;
      mem_address = cpu_address;
      mem_din     = cpu_memoryIn;
    end
  end

  assign cpu_memoryOut = mem_dout;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Self-checking bench for mem_boot_arbiter. Holds the 16x8 memory itself and
// predicts behaviour from an image-level model: a load count, a run flag and
// the expected memory contents. Debug checks are built with
// MEM_BOOT_ARBITER_DEBUG_EN.
module tb_mem_boot_arbiter;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       host_valid = 1'b0;
  logic [7:0] host_data = 8'h00;
  logic       host_last = 1'b0;
  logic       host_ready;
  logic       host_reload = 1'b0;
  logic       cpu_read = 1'b0;
  logic       cpu_write = 1'b0;
  logic [3:0] cpu_address = 4'h0;
  logic [7:0] cpu_memoryIn = 8'h00;
  logic [7:0] cpu_memoryOut;
  logic       cpu_clr;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_address;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       boot_done;
`ifdef MEM_BOOT_ARBITER_DEBUG_EN
  logic       dbg_req = 1'b0;
  logic [3:0] dbg_addr = 4'h0;
  logic       dbg_ack;
  logic [7:0] dbg_data;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit         modelRun;
  int         loadCount;
  logic [7:0] modelMem [16];

  // Bench-owned memory: combinational read, clocked write
  logic [7:0] memArr [16];

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) memArr[i] = 8'h00;
  always @(posedge clk) if (mem_write) memArr[mem_address] <= mem_din;
  assign mem_dout = memArr[mem_address];

  mem_boot_arbiter dut (
    .clk(clk), .clr(clr),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready), .host_reload(host_reload),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_memoryIn(cpu_memoryIn), .cpu_memoryOut(cpu_memoryOut), .cpu_clr(cpu_clr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_din(mem_din), .mem_dout(mem_dout), .boot_done(boot_done)
`ifdef MEM_BOOT_ARBITER_DEBUG_EN
    , .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
`endif
  );

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic modelReset();
    modelRun  = 1'b0;
    loadCount = 0;
  endtask

  task automatic checkLoadStatus(input string tag);
    check({tag, "_boot_done"}, boot_done, modelRun);
    check({tag, "_cpu_clr"}, cpu_clr, !modelRun);
    check({tag, "_host_ready"}, host_ready, !modelRun);
  endtask

  task automatic doReset();
    clr = 1'b1;
    host_valid = 1'b0;
    tick();
    clr = 1'b0;
    modelReset();
    settle();
    checkLoadStatus("reset");
    check("reset_mem_write", mem_write, 1'b0);
    check("reset_mem_read", mem_read, 1'b0);
  endtask

  task automatic loadByte(input logic [7:0] data, input bit last);
    host_valid = 1'b1;
    host_data  = data;
    host_last  = last;
    settle();
    check("load_mem_write", mem_write, 1'b1);
    check("load_mem_read", mem_read, 1'b0);
    check("load_mem_address", mem_address, loadCount[7:0]);
    check("load_mem_din", mem_din, data);
    check("load_cpu_clr", cpu_clr, 1'b1);
    tick();
    modelMem[loadCount] = data;
    if (last || loadCount == 15) begin
      modelRun  = 1'b1;
      loadCount = 0;
    end else begin
      loadCount++;
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    settle();
    checkLoadStatus("after_byte");
  endtask

  task automatic idleLoad();
    host_valid = 1'b0;
    settle();
    check("idle_mem_write", mem_write, 1'b0);
    check("idle_mem_read", mem_read, 1'b0);
    tick();
  endtask

  task automatic cpuOp(input bit rd, input bit wr, input logic [3:0] addr, input logic [7:0] data);
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_memoryIn = data;
    settle();
    check("cpu_mem_read", mem_read, rd);
    check("cpu_mem_write", mem_write, wr);
    check("cpu_mem_address", mem_address, addr);
    check("cpu_mem_din", mem_din, data);
    if (rd) check("cpu_read_data", cpu_memoryOut, modelMem[addr]);
    tick();
    if (wr) modelMem[addr] = data;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic doReload();
    host_reload = 1'b1;
    settle();
    tick();
    host_reload = 1'b0;
    modelReset();
    settle();
    checkLoadStatus("reload");
  endtask

  task automatic checkImage(input string tag);
    for (int i = 0; i < 16; i++) check(tag, memArr[i], modelMem[i]);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) modelMem[i] = 8'h00;
    doReset();

    // Short load terminated by host_last
    loadByte(8'h11, 1'b0);
    loadByte(8'h22, 1'b0);
    loadByte(8'h33, 1'b1);
    check("short_load_run", boot_done, 1'b1);
    checkImage("short_image");

    // CPU passthrough write then read-back
    cpuOp(1'b0, 1'b1, 4'd5, 8'hA5);
    cpuOp(1'b1, 1'b0, 4'd5, 8'h00);
    check("readback_a5", cpu_memoryOut, 8'hA5);

    // Random CPU traffic in RUN
    for (int i = 0; i < 30; i++)
      cpuOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    checkImage("cpu_image");

    // Full 16-byte load without host_last; reload ignored mid-load
    doReload();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) host_reload = 1'b1;
      loadByte(8'(i), 1'b0);
      host_reload = 1'b0;
      if (i == 14) check("full_still_load", boot_done, 1'b0);
    end
    check("full_load_run", boot_done, 1'b1);
    checkImage("full_image");

    // Pointer wrapped: the next load starts at address 0
    doReload();
    loadByte(8'hC3, 1'b1);
    checkImage("wrap_image");

    // Randomized loads with gaps, then some CPU traffic
    for (int r = 0; r < 6; r++) begin
      int n;
      bit lastOnFinal;
      doReload();
      n = $urandom_range(1, 16);
      lastOnFinal = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idleLoad();
        loadByte(8'($urandom_range(0, 255)), (i == n - 1) && lastOnFinal);
      end
      check("rand_load_run", boot_done, 1'b1);
      checkImage("rand_image");
      for (int i = 0; i < 5; i++)
        cpuOp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    // Reset after two accepted bytes restarts the image at address 0
    doReload();
    loadByte(8'h71, 1'b0);
    loadByte(8'h72, 1'b0);
    doReset();
    loadByte(8'h5A, 1'b1);
    checkImage("midreset_image");

    // Reset while running returns to LOAD
    doReset();
    loadByte(8'h11, 1'b0);
    loadByte(8'h22, 1'b0);
    loadByte(8'h33, 1'b1);

`ifdef MEM_BOOT_ARBITER_DEBUG_EN
    check("dbg_reset_ack", dbg_ack, 1'b0);
    // Debug request blocked by three CPU reads, granted on the first idle cycle
    dbg_req = 1'b1;
    dbg_addr = 4'd2;
    for (int i = 0; i < 3; i++) begin
      cpu_read = 1'b1;
      cpu_address = 4'(i + 7);
      settle();
      check("dbg_cpu_addr", mem_address, 4'(i + 7));
      check("dbg_cpu_data", cpu_memoryOut, modelMem[i + 7]);
      check("dbg_no_ack", dbg_ack, 1'b0);
      tick();
    end
    cpu_read = 1'b0;
    settle();
    check("grant_read", mem_read, 1'b1);
    check("grant_write", mem_write, 1'b0);
    check("grant_addr", mem_address, 4'd2);
    check("grant_no_ack", dbg_ack, 1'b0);
    tick();
    check("ack_pulse", dbg_ack, 1'b1);
    check("ack_data", dbg_data, 8'h33);
    check("ack_no_regrant", mem_read, 1'b0);
    dbg_req = 1'b0;
    tick();
    check("ack_single", dbg_ack, 1'b0);
    check("ack_hold", dbg_data, 8'h33);

    // Reload beats a coincident request; request served from the new image
    dbg_req = 1'b1;
    dbg_addr = 4'd0;
    host_reload = 1'b1;
    settle();
    check("reload_no_grant", mem_read, 1'b0);
    tick();
    host_reload = 1'b0;
    modelReset();
    settle();
    check("reload_cpu_clr", cpu_clr, 1'b1);
    check("reload_no_ack", dbg_ack, 1'b0);
    loadByte(8'h44, 1'b1);
    check("new_grant_read", mem_read, 1'b1);
    check("new_grant_addr", mem_address, 4'd0);
    tick();
    check("new_ack", dbg_ack, 1'b1);
    check("new_ack_data", dbg_data, 8'h44);
    dbg_req = 1'b0;
    tick();

    // Reset coinciding with an eligible request: no ack, data cleared
    dbg_req = 1'b1;
    dbg_addr = 4'd1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    dbg_req = 1'b0;
    modelReset();
    settle();
    check("clr_grant_no_ack", dbg_ack, 1'b0);
    check("clr_dbg_data", dbg_data, 8'h00);
    check("clr_grant_cpu_clr", cpu_clr, 1'b1);
    tick();
    check("clr_grant_no_late_ack", dbg_ack, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
